// File: rtl/nonce_hash_core.sv
// nonce_hash_core
//
// Per-nonce double-SHA-256 engine. Starting from a first-block midstate it
// compresses one prepared 16-word second block (phase 2), then hashes the
// resulting 256-bit digest as a single padded block (phase 3). It returns
// word 0 of the final digest.
//
// Ports:
//   clk            single clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   start          level request, sampled only in IDLE
//   input_message  phase-2 block words W0..W15 (word 0 consumed first)
//   input_hash0..7 midstate H0..H7
//   done           high while in DONE
//   output_mod     final digest word 0, valid while done=1, held until next start
//
// Handshake (four-phase): the requester raises start and keeps it up as long
// as it likes. Inputs are captured on the edge where IDLE sees start=1, and
// the computation then runs to completion regardless of start. done rises
// after the final add and stays high while start is high. Once start is low
// in DONE the block returns to IDLE on the next edge, and done falls with it.

module nonce_hash_core #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] input_message [16],
  input  logic [31:0] input_hash0,
  input  logic [31:0] input_hash1,
  input  logic [31:0] input_hash2,
  input  logic [31:0] input_hash3,
  input  logic [31:0] input_hash4,
  input  logic [31:0] input_hash5,
  input  logic [31:0] input_hash6,
  input  logic [31:0] input_hash7,
  output logic        done,
  output logic [31:0] output_mod
);

  typedef enum logic [2:0] {
    S_IDLE, S_P2, S_ADD2, S_P3, S_ADD3, S_DONE
  } state_t;

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] out_q, out_d;
  logic [31:0] mid_q [8];
  logic [31:0] mid_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] st_q [8];   // working variables a..h
  logic [31:0] st_d [8];

  logic [31:0] hash_in [8];
  logic [31:0] round_st [8];
  logic [31:0] d2 [8];
  logic [31:0] t1, t2, w_next;

  assign hash_in[0] = input_hash0;
  assign hash_in[1] = input_hash1;
  assign hash_in[2] = input_hash2;
  assign hash_in[3] = input_hash3;
  assign hash_in[4] = input_hash4;
  assign hash_in[5] = input_hash5;
  assign hash_in[6] = input_hash6;
  assign hash_in[7] = input_hash7;

  // One compression round plus the next schedule word; shared by P2 and P3.
  always_comb begin
    t1 = st_q[7] + bsig1(st_q[4]) + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]))
       + K[t_q] + w_q[0];
    t2 = bsig0(st_q[0]) + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));
    round_st[0] = t1 + t2;
    round_st[1] = st_q[0];
    round_st[2] = st_q[1];
    round_st[3] = st_q[2];
    round_st[4] = st_q[3] + t1;
    round_st[5] = st_q[4];
    round_st[6] = st_q[5];
    round_st[7] = st_q[6];
    w_next = w_q[0] + ssig0(w_q[1]) + w_q[9] + ssig1(w_q[14]);
    for (int i = 0; i < 8; i++) d2[i] = mid_q[i] + st_q[i];
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    out_d   = out_q;
    mid_d   = mid_q;
    w_d     = w_q;
    st_d    = st_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mid_d   = hash_in;
          w_d     = input_message;
          st_d    = hash_in;
          t_d     = 6'd0;
          state_d = S_P2;
        end
      end
      S_P2, S_P3: begin
        st_d = round_st;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_next;
        t_d     = t_q + 6'd1;
        if (t_q == LAST_T) begin
          t_d     = 6'd0;
          state_d = (state_q == S_P2) ? S_ADD2 : S_ADD3;
        end
      end
      S_ADD2: begin
        // Phase-3 block: the 256-bit phase-2 digest, padded for a 256-bit message.
        for (int i = 0; i < 8; i++) w_d[i] = d2[i];
        w_d[8] = 32'h80000000;
        for (int i = 9; i < 15; i++) w_d[i] = 32'h0;
        w_d[15] = 32'd256;
        st_d    = IV;
        t_d     = 6'd0;
        state_d = S_P3;
      end
      S_ADD3: begin
        out_d   = IV[0] + st_q[0];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= 6'd0;
      out_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      out_q   <= out_d;
    end
  end

  // Datapath registers carry no reset: they are always reloaded before use.
  always_ff @(posedge clk) begin
    mid_q <= mid_d;
    w_q   <= w_d;
    st_q  <= st_d;
  end

  assign done       = (state_q == S_DONE);
  assign output_mod = out_q;

endmodule
